// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
package regfile_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int REG_W  = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One write-back source (or the arbitrated write port)
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] data;
    } wb_port_t;

    // Single-bit mask for a register index
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        return NREGS'(1) << r;
    endfunction

endpackage

// File: rtl/regfile_access_ctrl_wb_arbiter.sv
// Two-source round-robin arbiter for the register-file write port.
module wb_arbiter
    import regfile_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  wb_port_t wb0,
    input  wb_port_t wb1,
    output logic     gnt0,
    output logic     gnt1,
    output wb_port_t wr
);
    logic ptr;   // 0: wb0 wins the next contended cycle
    logic both;

    assign both = wb0.valid && wb1.valid;

    // Grant: a lone requester always wins, contention goes by the pointer
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (both) begin
                gnt0 = !ptr;
                gnt1 = ptr;
            end else begin
                gnt0 = wb0.valid;
                gnt1 = wb1.valid;
            end
        end
    end

    // Mux the winner onto the write port; wr.valid is the write enable
    always_comb begin
        wr = '0;
        if (gnt0)      wr = wb0;
        else if (gnt1) wr = wb1;
    end

    // Pointer flips only when both sources competed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptr <= 1'b0;
        else if (both) ptr <= !ptr;
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Operand-fetch sequencer, busy scoreboard and write-port arbitration
// around a 1R/1W register file.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_W-1:0]  req_rs1,
    input  logic [REG_W-1:0]  req_rs2,
    input  logic              req_need_rs2,
    input  logic [REG_W-1:0]  req_rd,
    input  logic              req_has_rd,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [REG_W-1:0]  rf_read_reg_num,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              rf_write,
    output logic [REG_W-1:0]  rf_write_reg_num,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [REG_W-1:0]  wb0_reg,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [REG_W-1:0]  wb1_reg,
    input  logic [DATA_W-1:0] wb1_data,
    output logic [NREGS-1:0]  busy
);
    state_t            state;
    logic [REG_W-1:0]  rs1_q, rs2_q, rd_q;
    logic              need_rs2_q, has_rd_q;
    wb_port_t          wb0, wb1, wr;
    logic              fwd, rd_stall, waw, accept;
    logic [DATA_W-1:0] rd_data;
    logic [NREGS-1:0]  clr_vec, set_vec;

    assign wb0 = '{valid: wb0_valid, wreg: wb0_reg, data: wb0_data};
    assign wb1 = '{valid: wb1_valid, wreg: wb1_reg, data: wb1_data};

    wb_arbiter u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .wb0  (wb0),
        .wb1  (wb1),
        .gnt0 (wb0_ready),
        .gnt1 (wb1_ready),
        .wr   (wr)
    );

    assign rf_write         = wr.valid;
    assign rf_write_reg_num = wr.wreg;
    assign rf_write_data    = wr.data;

    // Read select follows the operand being fetched, 0 otherwise
    always_comb begin
        rf_read_reg_num = '0;
        case (state)
            READ_A:  rf_read_reg_num = rs1_q;
            READ_B:  rf_read_reg_num = rs2_q;
            default: rf_read_reg_num = '0;
        endcase
    end

    // A write landing on the read register this cycle both bypasses the
    // array (which only updates at the edge) and releases the stall.
    assign fwd      = rf_write && (rf_write_reg_num == rf_read_reg_num);
    assign rd_stall = busy[rf_read_reg_num] && !fwd;
    assign rd_data  = fwd ? rf_write_data : rf_read_data;

    // Hold off handing out a new rd while an older write to it is pending,
    // unless that older write retires this very cycle.
    assign waw = has_rd_q && busy[rd_q] && !(rf_write && (rf_write_reg_num == rd_q));

    assign req_ready = rst_n && (state == IDLE);
    assign op_valid  = rst_n && (state == DONE) && !waw;
    assign accept    = op_valid && op_ready;

    assign clr_vec = rf_write ? reg_onehot(rf_write_reg_num) : '0;
    assign set_vec = (accept && has_rd_q) ? reg_onehot(rd_q) : '0;

    // Scoreboard: retiring writes clear, issued ops set; set wins on a tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= (busy & ~clr_vec) | set_vec;
    end

    // Fetch sequencer: latch request, read rs1 then optionally rs2, present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            need_rs2_q <= 1'b0;
            has_rd_q   <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    rs1_q      <= req_rs1;
                    rs2_q      <= req_rs2;
                    need_rs2_q <= req_need_rs2;
                    rd_q       <= req_rd;
                    has_rd_q   <= req_has_rd;
                    op_b       <= '0;
                    state      <= READ_A;
                end
                READ_A: if (!rd_stall) begin
                    op_a  <= rd_data;
                    state <= need_rs2_q ? READ_B : DONE;
                end
                READ_B: if (!rd_stall) begin
                    op_b  <= rd_data;
                    state <= DONE;
                end
                DONE: if (accept) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench: the bench plays both the register array and the
// write-back pipeline; expected operands come from program-order register
// values, checked whenever the DUT hands operands downstream.
module tb_regfile_access_ctrl;
    import regfile_ctrl_pkg::*;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              req_valid, req_ready, req_need_rs2, req_has_rd;
    logic [REG_W-1:0]  req_rs1, req_rs2, req_rd;
    logic              op_valid, op_ready;
    logic [DATA_W-1:0] op_a, op_b;
    logic [REG_W-1:0]  rf_read_reg_num, rf_write_reg_num;
    logic [DATA_W-1:0] rf_read_data, rf_write_data;
    logic              rf_write;
    logic              wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [REG_W-1:0]  wb0_reg, wb1_reg;
    logic [DATA_W-1:0] wb0_data, wb1_data;
    logic [NREGS-1:0]  busy;

    regfile_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_need_rs2(req_need_rs2),
        .req_rd(req_rd), .req_has_rd(req_has_rd),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .rf_read_reg_num(rf_read_reg_num), .rf_read_data(rf_read_data),
        .rf_write(rf_write), .rf_write_reg_num(rf_write_reg_num), .rf_write_data(rf_write_data),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_reg(wb0_reg), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_reg(wb1_reg), .wb1_data(wb1_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DATA_W-1:0] a, b; logic [REG_W-1:0] rd; logic has; } exp_t;
    typedef struct { logic [REG_W-1:0] r; logic [DATA_W-1:0] d; int t; } job_t;

    exp_t              expq[$];
    job_t              wbq0[$], wbq1[$];
    int                gnt_log[$];
    logic [DATA_W-1:0] rf_mem [NREGS];
    logic [DATA_W-1:0] arch   [NREGS];   // program-order register values
    logic [NREGS-1:0]  outst;            // registers with an issued, unretired write
    int                cyc = 0, compared = 0, mismatched = 0;
    bit                wb_hold = 1'b0;
    int                rdy_mode = 0, jdly_max = 0, port_mode = 1, fixed_data = -1;
    logic              pend_has = 1'b0;
    logic [REG_W-1:0]  pend_rd = '0;

    assign rf_read_data = rf_mem[rf_read_reg_num];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Register array and write-back bookkeeping (pre-edge values at each edge)
    initial begin
        for (int i = 0; i < NREGS; i++) begin
            logic [DATA_W-1:0] v;
            v = DATA_W'($urandom);
            arch[i]   = v;
            rf_mem[i] <= v;
        end
        outst = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rf_write) rf_mem[rf_write_reg_num] <= rf_write_data;
            if (rst_n) begin
                if (wb0_valid && wb0_ready && wbq0.size() > 0) begin
                    gnt_log.push_back(0); outst[wb0_reg] = 1'b0; void'(wbq0.pop_front());
                end
                if (wb1_valid && wb1_ready && wbq1.size() > 0) begin
                    gnt_log.push_back(1); outst[wb1_reg] = 1'b0; void'(wbq1.pop_front());
                end
                if (op_valid && op_ready && pend_has) begin
                    job_t j;
                    j.r = pend_rd;
                    j.d = (fixed_data >= 0) ? fixed_data[DATA_W-1:0] : DATA_W'($urandom);
                    j.t = cyc + int'($urandom_range(0, jdly_max));
                    arch[pend_rd]  = j.d;
                    outst[pend_rd] = 1'b1;
                    if (port_mode == 1 || (port_mode == 0 && $urandom_range(0, 1) == 0)) wbq0.push_back(j);
                    else wbq1.push_back(j);
                end
            end
        end
    end

    // Write-back sources present their queue heads once due
    initial begin
        wb0_valid = 0; wb0_reg = '0; wb0_data = '0;
        wb1_valid = 0; wb1_reg = '0; wb1_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!wb_hold && wbq0.size() > 0 && cyc >= wbq0[0].t) begin
                wb0_valid = 1; wb0_reg = wbq0[0].r; wb0_data = wbq0[0].d;
            end else begin
                wb0_valid = 0; wb0_reg = REG_W'($urandom); wb0_data = DATA_W'($urandom);
            end
            if (!wb_hold && wbq1.size() > 0 && cyc >= wbq1[0].t) begin
                wb1_valid = 1; wb1_reg = wbq1[0].r; wb1_data = wbq1[0].d;
            end else begin
                wb1_valid = 0; wb1_reg = REG_W'($urandom); wb1_data = DATA_W'($urandom);
            end
        end
    end

    // Downstream readiness
    initial begin
        op_ready = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       op_ready = 1'b1;
                1:       op_ready = ($urandom_range(0, 3) != 0);
                default: op_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pop on every operand handoff, plus port checks
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("busy", 32'(busy), 32'(outst));
            if (wb0_valid && wb1_valid) check("arb_contend", 32'(wb0_ready ^ wb1_ready), 1);
            else check("arb_solo", {wb0_ready, wb1_ready}, {wb0_valid, wb1_valid});
            if (wb0_ready) begin
                check("wr_en0", 32'(rf_write), 1);
                check("wr_reg0", 32'(rf_write_reg_num), 32'(wb0_reg));
                check("wr_data0", 32'(rf_write_data), 32'(wb0_data));
            end else if (wb1_ready) begin
                check("wr_en1", 32'(rf_write), 1);
                check("wr_reg1", 32'(rf_write_reg_num), 32'(wb1_reg));
                check("wr_data1", 32'(rf_write_data), 32'(wb1_data));
            end else check("wr_idle", 32'(rf_write), 0);
            if (op_valid && op_ready) begin
                check("op_expected", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    exp_t e;
                    e = expq.pop_front();
                    check("op_a", 32'(op_a), 32'(e.a));
                    check("op_b", 32'(op_b), 32'(e.b));
                    pend_has = e.has;
                    pend_rd  = e.rd;
                end
            end
        end
    end

    task automatic tick; @(posedge clk); #1; endtask

    task automatic issue(input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                         input logic need, input logic [REG_W-1:0] rd, input logic has);
        int n = 0;
        while (!req_ready && n < 400) begin tick(); n++; end
        check("req_ready_wait", 32'(req_ready), 1);
        if (!req_ready) return;
        expq.push_back('{a: arch[rs1], b: need ? arch[rs2] : '0, rd: rd, has: has});
        req_valid = 1; req_rs1 = rs1; req_rs2 = rs2; req_need_rs2 = need; req_rd = rd; req_has_rd = has;
        tick();
        req_valid = 0;
    endtask

    // Negedges from the accept edge until op_valid; also the cycle-1 read select
    task automatic wait_valid(output int n, output logic [REG_W-1:0] sel1);
        n = 0; sel1 = '0;
        do begin
            @(negedge clk); n++;
            if (n == 1) sel1 = rf_read_reg_num;
        end while (!op_valid && n < 100);
    endtask

    task automatic push_wb(input int port, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
        job_t j;
        j.r = r; j.d = d; j.t = 0;
        arch[r] = d;
        if (port == 0) wbq0.push_back(j); else wbq1.push_back(j);
    endtask

    initial begin
        int               n, k;
        logic [REG_W-1:0] sel;
        req_valid = 0; req_rs1 = '0; req_rs2 = '0; req_need_rs2 = 0; req_rd = '0; req_has_rd = 0;
        repeat (2) @(negedge clk);
        check("rst_op_valid", 32'(op_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rf_write", 32'(rf_write), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_op_a", 32'(op_a), 0);
        rst_n = 1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 1);
        check("idle_rd_sel", 32'(rf_read_reg_num), 0);

        // Contended write-back from the reset pointer: wb0, wb1, wb0 ...
        push_wb(0, 2, 16'h1234); push_wb(0, 1, 16'h0011); push_wb(0, 0, 16'h0A0A);
        push_wb(1, 5, 16'h0055); push_wb(1, 4, 16'h0404); push_wb(1, 6, 16'h0606);
        k = 0;
        while ((wbq0.size() + wbq1.size()) != 0 && k < 50) begin tick(); k++; end
        check("arb_count", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) check("arb_order", gnt_log[i], i % 2);

        // One operand: op_valid two cycles after accept
        rdy_mode = 0; jdly_max = 0; port_mode = 1;
        issue(2, 0, 0, 0, 0);
        wait_valid(n, sel);
        check("lat_1op", n, 2);
        check("rd_sel_a", 32'(sel), 2);
        check("op_a_1234", 32'(op_a), 32'h1234);
        check("op_b_zero", 32'(op_b), 0);

        // Two operands with rd: three cycles, then rd marked busy
        wb_hold = 1; fixed_data = 32'hBEEF;
        tick();
        issue(1, 5, 1, 3, 1);
        wait_valid(n, sel);
        check("lat_2op", n, 3);
        check("op_a_0011", 32'(op_a), 32'h0011);
        check("op_b_0055", 32'(op_b), 32'h0055);
        @(negedge clk);
        check("busy_rd3", 32'(busy), 32'h08);

        // Read of busy r3 stalls until wb0 retires it, value forwarded
        issue(3, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        check("stall_valid", 32'(op_valid), 0);
        check("stall_sel", 32'(rf_read_reg_num), 3);
        wb_hold = 0;
        n = 2;
        do begin @(negedge clk); n++; end while (!op_valid && n < 100);
        check("lat_stall", n, 4);
        check("fwd_beef", 32'(op_a), 32'hBEEF);
        fixed_data = -1;

        // Downstream back-pressure: operands hold steady
        rdy_mode = 2;
        tick();
        issue(4, 6, 1, 0, 0);
        wait_valid(n, sel);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(op_valid), 1);
            check("hold_a", 32'(op_a), 32'(arch[4]));
            check("hold_b", 32'(op_b), 32'(arch[6]));
            check("hold_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        rdy_mode = 0;

        // Reset in READ_B drops the request and clears the scoreboard
        wb_hold = 1;
        tick();
        issue(0, 0, 0, 7, 1);
        issue(1, 2, 1, 0, 0);
        tick();
        #2 rst_n = 0;
        #1;
        check("rstb_op_valid", 32'(op_valid), 0);
        check("rstb_busy", 32'(busy), 0);
        check("rstb_req_ready", 32'(req_ready), 0);
        expq.delete(); wbq0.delete(); wbq1.delete(); outst = '0;
        for (int i = 0; i < NREGS; i++) arch[i] = rf_mem[i];
        @(negedge clk);
        rst_n = 1; wb_hold = 0;
        tick();
        check("rstb_idle_ready", 32'(req_ready), 1);
        check("rstb_idle_sel", 32'(rf_read_reg_num), 0);
        check("rstb_idle_valid", 32'(op_valid), 0);

        // Randomized traffic
        rdy_mode = 1; jdly_max = 6; port_mode = 0;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            issue(REG_W'($urandom), REG_W'($urandom), 1'($urandom), REG_W'($urandom), 1'($urandom));
        end
        k = 0;
        while (!(expq.size() == 0 && wbq0.size() == 0 && wbq1.size() == 0 && req_ready) && k < 3000) begin
            tick(); k++;
        end
        check("drain", 32'(expq.size() + wbq0.size() + wbq1.size()), 0);
        @(negedge clk);
        check("final_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Sequencer and write-port arbiter for the 8x16 single-read-port, single-write-port register file. It accepts one operand-fetch request at a time. It reads one or two source registers over consecutive cycles through the single read port, forwarding same-cycle write data, and hands the operands downstream. A busy-bit scoreboard stalls reads of registers with pending writes, and two write-back sources (ALU, MEM) share the write port under round-robin arbitration.

Parameters:
DATA_W, 16, register data width
NREGS, 8, number of registers
REG_W, 3, register index width, equals clog2(NREGS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  controller can accept request
req_rs1  in  REG_W  first source register
req_rs2  in  REG_W  second source register
req_need_rs2  in  1  request uses rs2
req_rd  in  REG_W  destination register
req_has_rd  in  1  request will write rd
op_valid  out  1  operands valid
op_ready  in  1  downstream accepts operands
op_a  out  DATA_W  operand from rs1
op_b  out  DATA_W  operand from rs2, 0 when unused
rf_read_reg_num  out  REG_W  to register file read select
rf_read_data  in  DATA_W  register file combinational read output
rf_write  out  1  register file write enable
rf_write_reg_num  out  REG_W  write index
rf_write_data  out  DATA_W  write data
wb0_valid/wb0_ready  in/out  1  ALU write-back handshake
wb0_reg  in  REG_W; wb0_data  in  DATA_W
wb1_valid/wb1_ready  in/out  1  MEM write-back handshake
wb1_reg  in  REG_W; wb1_data  in  DATA_W
busy  out  NREGS  scoreboard, for debug/visibility

Behaviour:
- Reset (async, rst_n=0): state IDLE, op_a=op_b=0, busy=0, latched request fields=0, round-robin pointer favours wb0.
- Outputs during reset: op_valid=0, req_ready=0, rf_write=0. A request in flight is dropped.
- FSM states are IDLE, READ_A, READ_B, DONE.
- IDLE: req_ready=1. On req_valid, latch rs1/rs2/need_rs2/rd/has_rd, clear op_b and move to READ_A. rf_read_reg_num=0.
- READ_A: rf_read_reg_num=rs1.
  - Stall: stays while busy[rs1]=1 and no write to rs1 is granted this cycle.
  - Otherwise capture op_a. The source is rf_write_data if a granted write targets rs1 this cycle (forward), else rf_read_data.
  - Next state is READ_B if need_rs2, else DONE.
- READ_B: same rules with rs2 into op_b, then DONE.
- DONE: op_valid=1 unless WAW, i.e. has_rd and busy[rd] with no clear of rd this cycle. Under WAW, op_valid=0 and the state holds.
  - On op_valid&op_ready: if has_rd, set busy[rd]; return to IDLE.
  - op_a/op_b hold stable while op_valid=1 and not accepted.
- Latency from accept edge: one-operand op_valid on cycle 2, two-operand on cycle 3, plus 1 per stall cycle. Back-to-back throughput is one request per 3 or 4 cycles.
- Write arbitration (combinational grant):
  - Only one valid: that port is granted.
  - Both valid: grant the port the pointer favours. The pointer then favours the other port; it changes only on a contended grant.
  - wbN_ready = granted. rf_write = any grant, carrying the granted reg/data.
- Scoreboard:
  - A grant clears busy[reg].
  - If a clear and a DONE set hit the same register in the same cycle, the set wins. WAW stall prevents this except when the old write retires.
- rf_read_data is used only in READ_A/READ_B.

Decomposition:
- Package regfile_ctrl_pkg: state enum (IDLE, READ_A, READ_B, DONE), DATA_W/REG_W/NREGS constants, write-back port struct {valid, reg, data}.
- Sub-module wb_arbiter: 2-port round-robin grant plus pointer register, also clocked by clk/rst_n.
- The top level holds the FSM, request latches and scoreboard.

Test Plan:
- Reset, then req rs1=2, need_rs2=0, regfile r2=0x1234 -> op_valid on cycle 2, op_a=0x1234, op_b=0, rf_read_reg_num=2 in READ_A.
- Req rs1=1, rs2=5, rd=3, has_rd; r1=0x0011, r5=0x0055 -> op_valid on cycle 3, op_a=0x0011, op_b=0x0055; after accept busy=0x08.
- busy[3]=1, req rs1=3; wb0 writes r3=0xBEEF two cycles later -> READ_A stalls, op_a=0xBEEF (forwarded) on the grant cycle, busy[3] cleared.
- wb0 and wb1 valid on 3 consecutive cycles -> grants wb0, wb1, wb0; rf_write_data follows the granted port.
- Hold op_ready=0 for 5 cycles in DONE -> op_valid stays 1, op_a/op_b unchanged, req_ready=0.
- Assert rst_n=0 during READ_B -> immediately op_valid=0, busy=0; after release req_ready=1 and the FSM is in IDLE.
